hex_write_sequencer: RTL and testbench

Hardware sequencer that drives a bank of 7-segment hex PIO peripherals from a single packed hexadecimal value, without CPU involvement. It sits as an Avalon-MM write-only master in front of up to eight 7-bit hex output PIO slaves (one chipselect each, register at address 0). On a start request it decodes each nibble to a segment pattern and issues one single-cycle write per digit. Digits whose pattern is unchanged since the last write are skipped unless a forced update is requested.

---
 rtl/hex_write_sequencer_if.sv | 24 ++
 rtl/hex_write_sequencer.sv | 128 ++++++++++++
 tb/tb_hex_write_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hex_write_sequencer_if.sv
// Avalon-MM write-only bus between the sequencer (master) and a bank of
// 7-segment hex PIO slaves, one chipselect per slave.
interface hex_write_sequencer_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0] avm_chipselect;
  logic [1:0]            avm_address;
  logic                  avm_write_n;
  logic [31:0]           avm_writedata;

  modport master (
    output avm_chipselect,
    output avm_address,
    output avm_write_n,
    output avm_writedata
  );

  modport slave (
    input avm_chipselect,
    input avm_address,
    input avm_write_n,
    input avm_writedata
  );
endinterface

// File: rtl/hex_write_sequencer.sv
// Walks the digits of a packed hex value and writes each decoded segment
// pattern to its own PIO slave, one strobe every other cycle. Digits whose
// pattern matches the last written value are skipped unless forced, but the
// slot is still consumed so the sequence length never varies.
module hex_write_sequencer #(
  parameter int NUM_DIGITS = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    force_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  hex_write_sequencer_if.master   avm
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    force_q;
  logic                    valid_q;
  logic [6:0]              shadow_q [NUM_DIGITS];

  logic                    accept;
  logic                    wr_en;
  logic [6:0]              code;
  logic [NUM_DIGITS-1:0]   cs;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  // Pattern for the digit currently addressed, polarity already applied.
  always_comb begin
    code = blank_q[idx_q] ? 7'h00 : seg7(value_q[idx_q*4 +: 4]);
    if (ACTIVE_LOW) code = ~code;
  end

  // Next-state logic and write decision; writes only happen in WRITE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en   = force_q || !valid_q || (code != shadow_q[idx_q]);
        state_d = (idx_q == LAST_IDX) ? DONE : GAP;
      end
      GAP: begin
        idx_d   = idx_q + 1'b1;
        state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, captured request and shadow-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      value_q <= '0;
      blank_q <= '0;
      force_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        value_q <= value_i;
        blank_q <= blank_i;
        force_q <= force_i;
      end
      if (state_q == DONE) valid_q <= 1'b1;
    end
  end

  // Shadow copy of what each slave holds; meaningful only while valid_q is set.
  always_ff @(posedge clk) begin
    if (wr_en) shadow_q[idx_q] <= code;
  end

  // One-hot chipselect for the digit being written this cycle.
  always_comb begin
    cs = '0;
    if (wr_en) cs[idx_q] = 1'b1;
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == DONE);
  assign avm.avm_chipselect = cs;
  assign avm.avm_address    = 2'b00;
  assign avm.avm_write_n    = ~wr_en;
  assign avm.avm_writedata  = wr_en ? {25'b0, code} : 32'h0;

endmodule

// File: tb/tb_hex_write_sequencer.sv
// Directed bench: two sequencers (active-low and active-high segments) share
// one set of control inputs; each step checks the cycle-by-cycle bus activity
// of one of them against hand-computed patterns.
module tb_hex_write_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        force_up;
  logic        start;
  logic        busy_a, done_a, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  hex_write_sequencer_if #(.NUM_DIGITS(4)) a_if ();
  hex_write_sequencer_if #(.NUM_DIGITS(4)) b_if ();

  hex_write_sequencer #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value_i(value), .blank_i(blank),
    .force_i(force_up), .start_i(start), .busy_o(busy_a), .done_o(done_a),
    .avm(a_if.master)
  );

  hex_write_sequencer #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value_i(value), .blank_i(blank),
    .force_i(force_up), .start_i(start), .busy_o(busy_b), .done_o(done_b),
    .avm(b_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then check cycles 1..9 of the sequence on DUT a (sel=0) or b (sel=1).
  // ed holds digit i's expected data at [7i+6:7i]; ew[i] says whether it is written.
  task automatic run_seq(input bit sel, input logic [27:0] ed, input logic [3:0] ew,
                         input string name);
    logic [3:0]  cs;
    logic [31:0] wd;
    logic        wn, bz, dn;
    int          i;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      cs = sel ? b_if.avm_chipselect : a_if.avm_chipselect;
      wd = sel ? b_if.avm_writedata  : a_if.avm_writedata;
      wn = sel ? b_if.avm_write_n    : a_if.avm_write_n;
      bz = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      chk($sformatf("%s_busy_c%0d", name, c), {31'b0, bz}, {31'b0, (c <= 8)});
      chk($sformatf("%s_done_c%0d", name, c), {31'b0, dn}, {31'b0, (c == 8)});
      if ((c % 2 == 1) && (c <= 7) && ew[(c-1)/2]) begin
        i = (c - 1) / 2;
        chk($sformatf("%s_cs_c%0d", name, c), {28'b0, cs}, 32'(4'b0001 << i));
        chk($sformatf("%s_wn_c%0d", name, c), {31'b0, wn}, 32'd0);
        chk($sformatf("%s_wd_c%0d", name, c), wd, {25'b0, ed[7*i +: 7]});
      end else begin
        chk($sformatf("%s_cs_c%0d", name, c), {28'b0, cs}, 32'd0);
        chk($sformatf("%s_wn_c%0d", name, c), {31'b0, wn}, 32'd1);
        chk($sformatf("%s_wd_c%0d", name, c), wd, 32'd0);
      end
      $display("[TB] %s cycle %0d: cs=%b wn=%b wd=%02h busy=%b done=%b",
               name, c, cs, wn, wd, bz, dn);
      if (c < 9) @(negedge clk);
    end
  endtask

  int         done_cnt;
  int         cs_viol;
  logic [3:0] prev_cs;

  initial begin
    rst = 1'b1; value = 16'h0; blank = 4'h0; force_up = 1'b0; start = 1'b0;
    #1;
    // Reset state, checked while reset is still asserted.
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_cs",   {28'b0, a_if.avm_chipselect}, 32'd0);
    chk("rst_wn",   {31'b0, a_if.avm_write_n}, 32'd1);
    chk("rst_wd",   a_if.avm_writedata, 32'd0);
    chk("rst_addr", {30'b0, a_if.avm_address}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First sequence after reset writes everything: 4,3,2,1 inverted.
    value = 16'h1234;
    run_seq(1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, "first");

    // Only digit0 changes (4 -> 9).
    value = 16'h1239;
    run_seq(1'b0, {7'h79, 7'h24, 7'h30, 7'h10}, 4'b0001, "skip");

    // Forced: identical data rewritten everywhere.
    force_up = 1'b1;
    run_seq(1'b0, {7'h79, 7'h24, 7'h30, 7'h10}, 4'b1111, "force");
    force_up = 1'b0;

    // Active-high instance with the top digit blanked: D, C, b, blank.
    value = 16'hABCD; blank = 4'b1000;
    run_seq(1'b1, {7'h00, 7'h7C, 7'h39, 7'h5E}, 4'b1111, "blank");
    blank = 4'b0000;

    // Start held high: a new acceptance every 9 cycles, never overlapping.
    done_cnt = 0; cs_viol = 0; prev_cs = 4'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (done_a) done_cnt++;
      if (!$onehot0(a_if.avm_chipselect) || ((prev_cs != 0) && (a_if.avm_chipselect != 0)))
        cs_viol++;
      prev_cs = a_if.avm_chipselect;
      if (c == 9 || c == 18 || c == 27)
        chk($sformatf("hold_busy_c%0d", c), {31'b0, busy_a}, 32'd0);
      if (c == 10 || c == 28)
        chk($sformatf("hold_busy_c%0d", c), {31'b0, busy_a}, 32'd1);
      if (c == 30) start = 1'b0;
      if (c == 30) chk("hold_done_cnt_30", 32'(done_cnt), 32'd3);
    end
    chk("hold_done_cnt_38", 32'(done_cnt), 32'd4);
    chk("hold_cs_rules", 32'(cs_viol), 32'd0);
    chk("hold_idle_end", {31'b0, busy_a}, 32'd0);
    $display("[TB] held start: %0d done pulses, %0d chipselect violations", done_cnt, cs_viol);

    // Reset during cycle 4 of a sequence.
    value = 16'h5678;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy_a}, 32'd0);
    chk("midrst_cs",   {28'b0, a_if.avm_chipselect}, 32'd0);
    chk("midrst_wn",   {31'b0, a_if.avm_write_n}, 32'd1);
    chk("midrst_wd",   a_if.avm_writedata, 32'd0);
    $display("[TB] mid-sequence reset: busy=%b cs=%b", busy_a, a_if.avm_chipselect);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_still_idle", {31'b0, busy_a}, 32'd0);
    rst = 1'b0;

    // Shadow invalidated: same value writes all four digits (8,7,6,5 inverted).
    run_seq(1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
